// File: rtl/ram_scan_reader.sv
// ram_scan_reader
//   Read-side companion for the single-port RAM demo. Sweeps every RAM address
//   in order, converts each word to decimal tens/units digits by repeated
//   subtraction (one subtract-by-10 per cycle) and holds the result for DWELL
//   cycles so the two 7-segment decoders can show it.
//
//   Parameters
//     DW      RAM data width (1..6, so the tens digit never exceeds 6)
//     AW      RAM address width; the sweep covers 2**AW words
//     RD_LAT  cycles from an address change until rd is valid (>= 1)
//     DWELL   cycles each result is held with valid=1 (>= 1)
//
//   Ports
//     clk, rst_n   clock (rising edge), asynchronous active-low reset
//     start        one-cycle request to begin a sweep (honoured only when idle)
//     stop         abort the sweep; back to idle on the next cycle
//     loop         1 = wrap to address 0 after the last word, 0 = single sweep
//     addr         RAM read address
//     rd           RAM read data
//     digit_high   tens digit of the displayed word
//     digit_low    units digit of the displayed word
//     valid        high while the digits for addr are being held
//     busy         high whenever the reader is not idle
//     done         one-cycle pulse when a single sweep finishes
//
//   Build option
//     RAM_SCAN_SKIP_ZERO_EN  when defined, a word read as 0 is not displayed:
//                            the reader advances straight to the next address
//                            (same wrap/done rules), valid stays low and the
//                            digits keep their previous value.
module ram_scan_reader #(
  parameter int DW     = 4,
  parameter int AW     = 2,
  parameter int RD_LAT = 1,
  parameter int DWELL  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  output logic [AW-1:0] addr,
  input  logic [DW-1:0] rd,
  output logic [3:0]    digit_high,
  output logic [3:0]    digit_low,
  output logic          valid,
  output logic          busy,
  output logic          done
);

  // Remainder is at least 4 bits wide so the units digit can be taken directly.
  localparam int RW   = (DW < 4) ? 4 : DW;
  localparam int CMAX = (RD_LAT > DWELL) ? RD_LAT : DWELL;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [AW-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {IDLE, READ, CONV, HOLD} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] addr_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [3:0]    digit_high_nx, digit_low_nx;
  logic          valid_nx, done_nx;
  logic          adv;
  logic [RW-1:0] rem, rem_nx;
  logic [3:0]    tens, tens_nx;

  always_comb begin
    state_nx      = state;
    addr_nx       = addr;
    cnt_nx        = cnt;
    digit_high_nx = digit_high;
    digit_low_nx  = digit_low;
    valid_nx      = 1'b0;
    done_nx       = 1'b0;
    rem_nx        = rem;
    tens_nx       = tens;
    adv           = 1'b0;

    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nx = READ;
          addr_nx  = '0;
          cnt_nx   = '0;
        end
      end
      READ: begin
        if (cnt == CW'(RD_LAT - 1)) begin
          cnt_nx   = '0;
          rem_nx   = RW'(rd);
          tens_nx  = 4'd0;
          state_nx = CONV;
`ifdef RAM_SCAN_SKIP_ZERO_EN
          if (rd == '0) adv = 1'b1;
`endif
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      CONV: begin
        if (rem >= RW'(10)) begin
          rem_nx  = rem - RW'(10);
          tens_nx = tens + 4'd1;
        end else begin
          state_nx      = HOLD;
          digit_high_nx = tens;
          digit_low_nx  = rem[3:0];
          valid_nx      = 1'b1;
          cnt_nx        = '0;
        end
      end
      HOLD: begin
        if (cnt == CW'(DWELL - 1)) begin
          adv = 1'b1;
        end else begin
          cnt_nx   = cnt + 1'b1;
          valid_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Step to the next word: either after a full HOLD or after a skipped zero.
    if (adv) begin
      cnt_nx = '0;
      if (addr != LAST_ADDR) begin
        addr_nx  = addr + 1'b1;
        state_nx = READ;
      end else begin
        addr_nx = '0;
        if (loop) begin
          state_nx = READ;
        end else begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
    end

    // stop overrides everything else but leaves the displayed digits alone.
    if (stop && state != IDLE) begin
      state_nx      = IDLE;
      addr_nx       = '0;
      cnt_nx        = '0;
      valid_nx      = 1'b0;
      done_nx       = 1'b0;
      digit_high_nx = digit_high;
      digit_low_nx  = digit_low;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      cnt        <= '0;
      digit_high <= 4'd0;
      digit_low  <= 4'd0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      addr       <= addr_nx;
      cnt        <= cnt_nx;
      digit_high <= digit_high_nx;
      digit_low  <= digit_low_nx;
      valid      <= valid_nx;
      busy       <= (state_nx != IDLE);
      done       <= done_nx;
    end
  end

  // Conversion datapath; always reloaded in READ before it is used.
  always_ff @(posedge clk) begin
    rem  <= rem_nx;
    tens <= tens_nx;
  end

  always @(posedge clk) begin
    if (rst_n && valid) begin
      assert (digit_low <= 4'd9);
      if (DW <= 6) assert (digit_high <= 4'd6);
    end
  end

endmodule

// File: tb/tb_ram_scan_reader.sv
// Testbench for ram_scan_reader (DW=6, AW=2, RD_LAT=1, DWELL=4) with an
// asynchronous-read RAM model. Table-driven sweeps plus sequences for loop,
// stop and asynchronous reset; displayed words are checked via a queue.
module tb_ram_scan_reader;

  localparam int DW = 6;
  localparam int AW = 2;
  localparam int DWELL = 4;
`ifdef RAM_SCAN_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          stop;
  logic          lp;
  logic [AW-1:0] addr;
  logic [DW-1:0] rd;
  logic [3:0]    digit_high;
  logic [3:0]    digit_low;
  logic          valid;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [4];
  assign rd = mem[addr];

  ram_scan_reader #(.DW(DW), .AW(AW), .RD_LAT(1), .DWELL(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(lp),
    .addr(addr), .rd(rd), .digit_high(digit_high), .digit_low(digit_low),
    .valid(valid), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][5:0] w;
    logic [3:0][3:0] h;
    logic [3:0][3:0] l;
  } vec_t;

  typedef struct {
    int a;
    int h;
    int l;
  } exp_t;

  vec_t tv [4];
  exp_t q [$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   done_cnt = 0;
  bit   expect_cut = 1'b0;
  bit   valid_d = 1'b0;
  int   vcount = 0;

  task automatic check(input string nm, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", nm, act, req);
  endtask

  function automatic vec_t mk(input int a0, a1, a2, a3,
                              input int h0, l0, h1, l1, h2, l2, h3, l3);
    vec_t v;
    v.w[0] = 6'(a0); v.w[1] = 6'(a1); v.w[2] = 6'(a2); v.w[3] = 6'(a3);
    v.h[0] = 4'(h0); v.h[1] = 4'(h1); v.h[2] = 4'(h2); v.h[3] = 4'(h3);
    v.l[0] = 4'(l0); v.l[1] = 4'(l1); v.l[2] = 4'(l2); v.l[3] = 4'(l3);
    return v;
  endfunction

  task automatic push_word(input vec_t v, input int j);
    exp_t e;
    e.a = j;
    e.h = int'(v.h[j]);
    e.l = int'(v.l[j]);
    q.push_back(e);
  endtask

  task automatic load_mem(input vec_t v);
    for (int j = 0; j < 4; j++) mem[j] = v.w[j];
  endtask

  // Scoreboard monitor: pops one expected word on every rising edge of valid
  // and checks the hold length on every falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      valid_d    = 1'b0;
      vcount     = 0;
      expect_cut = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (valid && !valid_d) begin
        vcount = 0;
        if (q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = q.pop_front();
          check("word_addr", int'(addr), e.a);
          check("digit_high", int'(digit_high), e.h);
          check("digit_low", int'(digit_low), e.l);
        end
      end
      if (valid) vcount++;
      if (!valid && valid_d) begin
        if (expect_cut) expect_cut = 1'b0;
        else check("dwell_cycles", vcount, DWELL);
      end
      valid_d = valid;
    end
  end

  // Single sweep of one table entry, loop=0.
  task automatic run_vec(input vec_t v);
    int k;
    int exp_k;
    int j;
    bit seen;
    load_mem(v);
    lp = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 4; i++) if (!SKIP || v.w[i] != 0) push_word(v, i);
    // Start in cycle 0: READ cycle 1, CONV floor(v/10)+1 cycles, then HOLD.
    exp_k = 3;
    j = 0;
    while (SKIP && j < 3 && v.w[j] == 0) begin
      exp_k++;
      j++;
    end
    exp_k += int'(v.w[j]) / 10;
    @(negedge clk);
    start = 1'b1;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clk);
      start = 1'b0;
      k++;
      if (valid) seen = 1'b1;
    end
    check("first_valid_cycle", seen ? k : -1, exp_k);
    k = 0;
    while (!done && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", int'(done), 1);
    check("busy_at_done", int'(busy), 0);
    check("addr_at_done", int'(addr), 0);
    @(negedge clk);
    @(negedge clk);
    check("done_pulses", done_cnt, 1);
    check("queue_drained", q.size(), 0);
    q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got 1, required 0");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    tv[0] = mk(3, 9, 10, 15,   0, 3, 0, 9, 1, 0, 1, 5);
    tv[1] = mk(0, 7, 0, 12,    0, 0, 0, 7, 0, 0, 1, 2);
    tv[2] = mk(63, 42, 1, 59,  6, 3, 4, 2, 0, 1, 5, 9);
    tv[3] = mk(15, 30, 19, 50, 1, 5, 3, 0, 1, 9, 5, 0);

    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    lp    = 1'b0;
    load_mem(tv[0]);
    repeat (3) @(negedge clk);
    check("rst_addr", int'(addr), 0);
    check("rst_digits", int'({digit_high, digit_low}), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) run_vec(tv[i]);

    // Looping: two full sweeps and the start of a third, no done pulse, then stop.
    load_mem(tv[0]);
    lp = 1'b1;
    done_cnt = 0;
    for (int s = 0; s < 2; s++) for (int j = 0; j < 4; j++) push_word(tv[0], j);
    push_word(tv[0], 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (q.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    check("loop_words_shown", q.size(), 0);
    @(negedge clk);
    expect_cut = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    lp = 1'b0;
    check("loop_no_done", done_cnt, 0);
    check("loop_stop_valid", int'(valid), 0);
    check("loop_stop_busy", int'(busy), 0);
    check("loop_stop_digits", int'({digit_high, digit_low}), 8'h03);

    // stop together with start mid-HOLD on addr 2.
    done_cnt = 0;
    for (int j = 0; j < 3; j++) push_word(tv[0], j);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(valid && addr == 2'd2) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("stop_reached_addr2", int'(valid && addr == 2'd2), 1);
    expect_cut = 1'b1;
    stop  = 1'b1;
    start = 1'b1;
    @(negedge clk);
    stop  = 1'b0;
    start = 1'b0;
    check("stop_valid", int'(valid), 0);
    check("stop_addr", int'(addr), 0);
    check("stop_busy", int'(busy), 0);
    check("stop_done", int'(done), 0);
    check("stop_digits", int'({digit_high, digit_low}), 8'h10);
    repeat (3) @(negedge clk);
    check("stop_start_ignored", int'(busy), 0);
    check("stop_queue", q.size(), 0);

    // Asynchronous reset in the middle of a long conversion.
    mem[0] = 6'd63;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_addr", int'(addr), 0);
    check("arst_digits", int'({digit_high, digit_low}), 0);
    check("arst_valid", int'(valid), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(tv[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
